// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   RV32I decode/issue stage feeding the ALU. Takes one instruction + PC per
//   valid/ready handshake, reads the internal 32x32 register file, builds the
//   immediate, tracks outstanding destinations in a busy scoreboard and
//   presents a registered operand bundle to the execute stage. Writeback from
//   the end of the pipe updates the register file and clears busy bits.
//
//   Optional feature macro: ALU_ISSUE_BYPASS_EN
//     defined   - a same-cycle writeback to a source register satisfies the
//                 hazard and its data is forwarded into the operand.
//     undefined - no forwarding; a stalled source resumes the cycle after
//                 its writeback.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        instruction handshake
//   in_instr, in_pc          instruction word and its PC
//   out_valid/out_ready      issue bundle handshake
//   opcode, func3, func7     instr[6:2], instr[14:12], instr[30]
//   operand1, operand2       ALU operands
//   imm                      sign-extended immediate (B-imm for branches)
//   rd, rd_we                destination register and its write enable
//   illegal                  unsupported opcode
//   wb_en, wb_rd, wb_data    writeback port
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      opcode,
    output logic [2:0]      func3,
    output logic            func7,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            illegal,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;

    logic [XLEN-1:0] rf [32];
    logic [31:0]     busy;          // bit 0 is never set
    logic [31:0]     busy_next;

    logic [4:0]             op_p0, rs1_p0, rs2_p0, rd_p0;
    logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0]        rs1_val, rs2_val;
    logic [XLEN-1:0]        op1_p0, op2_p0, imm_p0;
    logic                   use_rs1, use_rs2, writes_rd, ill_p0, rd_we_p0;
    logic                   fwd_rs1, fwd_rs2, hazard, accept;

    logic                   vld_p1;
    logic [4:0]             opcode_p1, rd_p1;
    logic [2:0]             func3_p1;
    logic                   func7_p1, rd_we_p1, ill_p1;
    logic [XLEN-1:0]        op1_p1, op2_p1, imm_p1;

    // ---- stage p0: decode, register read, hazard check ----
    assign op_p0  = in_instr[6:2];
    assign rs1_p0 = in_instr[19:15];
    assign rs2_p0 = in_instr[24:20];
    assign rd_p0  = in_instr[11:7];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

`ifdef ALU_ISSUE_BYPASS_EN
    assign fwd_rs1 = wb_en && (wb_rd == rs1_p0) && (rs1_p0 != 5'd0);
    assign fwd_rs2 = wb_en && (wb_rd == rs2_p0) && (rs2_p0 != 5'd0);
`else
    assign fwd_rs1 = 1'b0;
    assign fwd_rs2 = 1'b0;
`endif

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (fwd_rs1)              rs1_val = wb_data;
        else if (rs1_p0 != 5'd0)  rs1_val = rf[rs1_p0];
        if (fwd_rs2)              rs2_val = wb_data;
        else if (rs2_p0 != 5'd0)  rs2_val = rf[rs2_p0];
    end

    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        ill_p0    = 1'b0;
        op1_p0    = '0;
        op2_p0    = '0;
        imm_p0    = '0;
        case (op_p0)
            OPC_LUI:    begin writes_rd = 1'b1; op2_p0 = {12'b0, in_instr[31:12]}; imm_p0 = imm_u; end
            OPC_AUIPC:  begin writes_rd = 1'b1; op1_p0 = in_pc; op2_p0 = imm_u; imm_p0 = imm_u; end
            OPC_JAL:    begin writes_rd = 1'b1; op1_p0 = in_pc; op2_p0 = imm_j; imm_p0 = imm_j; end
            OPC_JALR:   begin use_rs1 = 1'b1; writes_rd = 1'b1; op1_p0 = rs1_val; op2_p0 = imm_i; imm_p0 = imm_i; end
            OPC_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; op1_p0 = rs1_val; op2_p0 = rs2_val; imm_p0 = imm_b; end
            OPC_LOAD:   begin use_rs1 = 1'b1; writes_rd = 1'b1; op1_p0 = rs1_val; op2_p0 = imm_i; imm_p0 = imm_i; end
            OPC_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; op1_p0 = rs1_val; op2_p0 = imm_s; imm_p0 = imm_s; end
            OPC_OPIMM:  begin use_rs1 = 1'b1; writes_rd = 1'b1; op1_p0 = rs1_val; op2_p0 = imm_i; imm_p0 = imm_i; end
            OPC_OP:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1; op1_p0 = rs1_val; op2_p0 = rs2_val; end
            default:    ill_p0 = 1'b1;
        endcase
        // Non-32-bit encodings (low bits != 11) are not RV32I instructions.
        if (in_instr[1:0] != 2'b11) begin
            use_rs1   = 1'b0;
            use_rs2   = 1'b0;
            writes_rd = 1'b0;
            ill_p0    = 1'b1;
            op1_p0    = '0;
            op2_p0    = '0;
            imm_p0    = '0;
        end
    end

    assign rd_we_p0 = writes_rd && (rd_p0 != 5'd0);

    // busy[0] is always clear, so x0 sources never stall.
    assign hazard = (use_rs1 && busy[rs1_p0] && !fwd_rs1) ||
                    (use_rs2 && busy[rs2_p0] && !fwd_rs2);
    assign in_ready = !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Set after clear so an accept wins over a same-cycle writeback.
    always_comb begin
        busy_next = busy;
        if (wb_en && (wb_rd != 5'd0)) busy_next[wb_rd] = 1'b0;
        if (accept && rd_we_p0)       busy_next[rd_p0] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // ---- stage p1: registered issue bundle, register file, scoreboard ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            busy      <= '0;
            opcode_p1 <= '0;
            func3_p1  <= '0;
            func7_p1  <= 1'b0;
            op1_p1    <= '0;
            op2_p1    <= '0;
            imm_p1    <= '0;
            rd_p1     <= '0;
            rd_we_p1  <= 1'b0;
            ill_p1    <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            busy <= busy_next;
            if (wb_en && (wb_rd != 5'd0)) rf[wb_rd] <= wb_data;
            if (accept) begin
                vld_p1    <= 1'b1;
                opcode_p1 <= op_p0;
                func3_p1  <= in_instr[14:12];
                func7_p1  <= in_instr[30];
                op1_p1    <= op1_p0;
                op2_p1    <= op2_p0;
                imm_p1    <= imm_p0;
                rd_p1     <= rd_p0;
                rd_we_p1  <= rd_we_p0;
                ill_p1    <= ill_p0;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign opcode    = opcode_p1;
    assign func3     = func3_p1;
    assign func7     = func7_p1;
    assign operand1  = op1_p1;
    assign operand2  = op2_p1;
    assign imm       = imm_p1;
    assign rd        = rd_p1;
    assign rd_we     = rd_we_p1;
    assign illegal   = ill_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
//   Self-checking bench for alu_issue_stage: directed scenarios followed by a
//   randomized run, all compared against a behavioural model of the stage
//   (register array, busy flags, one-entry output bundle).
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  opcode, rd;
    logic [2:0]  func3;
    logic        func7, rd_we, illegal;
    logic [31:0] operand1, operand2, imm;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .func3(func3), .func7(func7),
        .operand1(operand1), .operand2(operand2), .imm(imm),
        .rd(rd), .rd_we(rd_we), .illegal(illegal),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_rf [32];
    bit   [31:0] m_busy;
    bit          m_valid;
    logic [79:0] m_exp;       // {opcode,func3,func7,op1,op2,rd,rd_we,illegal}
    logic [31:0] m_imm;
    bit          m_imm_care;
    bit          obs_rdy;     // in_ready seen in the most recent cycle

    function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] v1, input logic [31:0] v2,
                                       output bit u1, output bit u2, output bit wr,
                                       output bit ill, output logic [31:0] a,
                                       output logic [31:0] b, output logic [31:0] im);
        logic [31:0] sgn, i_imm, s_imm, b_imm, u_imm, j_imm;
        sgn   = {32{ins[31]}};
        i_imm = (sgn << 12) | 32'(ins[31:20]);
        s_imm = (sgn << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
        b_imm = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        u_imm = ins & 32'hFFFF_F000;
        j_imm = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        u1 = 0; u2 = 0; wr = 0; ill = 0; a = 0; b = 0; im = 0;
        case (ins[6:2])
            5'b01101: begin wr = 1; b = ins >> 12; im = u_imm; end
            5'b00101: begin wr = 1; a = pc; b = u_imm; im = u_imm; end
            5'b11011: begin wr = 1; a = pc; b = j_imm; im = j_imm; end
            5'b11001: begin u1 = 1; wr = 1; a = v1; b = i_imm; im = i_imm; end
            5'b11000: begin u1 = 1; u2 = 1; a = v1; b = v2; im = b_imm; end
            5'b00000: begin u1 = 1; wr = 1; a = v1; b = i_imm; im = i_imm; end
            5'b01000: begin u1 = 1; u2 = 1; a = v1; b = s_imm; im = s_imm; end
            5'b00100: begin u1 = 1; wr = 1; a = v1; b = i_imm; im = i_imm; end
            5'b01100: begin u1 = 1; u2 = 1; wr = 1; a = v1; b = v2; end
            default:  ill = 1;
        endcase
    endfunction

    // One clock cycle: drive inputs at the falling edge, check in_ready,
    // advance the model, then check the registered outputs after the edge.
    task automatic cycle(input bit r, input bit v, input logic [31:0] ins,
                         input logic [31:0] pc, input bit ordy, input bit wbe,
                         input logic [4:0] wrd, input logic [31:0] wdat);
        bit          u1, u2, wr, ill, haz, exp_rdy, acc;
        logic [31:0] v1, v2, a, b, im;
        logic [4:0]  s1, s2, d;
        logic [79:0] act;
        rst = r; in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy;
        wb_en = wbe; wb_rd = wrd; wb_data = wdat;
        #1;
        s1 = ins[19:15]; s2 = ins[24:20]; d = ins[11:7];
        v1 = (s1 == 0) ? 32'd0 : (BYP && wbe && wrd == s1) ? wdat : m_rf[s1];
        v2 = (s2 == 0) ? 32'd0 : (BYP && wbe && wrd == s2) ? wdat : m_rf[s2];
        ref_decode(ins, pc, v1, v2, u1, u2, wr, ill, a, b, im);
        haz = (u1 && s1 != 0 && m_busy[s1] && !(BYP && wbe && wrd == s1)) ||
              (u2 && s2 != 0 && m_busy[s2] && !(BYP && wbe && wrd == s2));
        exp_rdy = !haz && (!m_valid || ordy);
        obs_rdy = in_ready;
        acc = 0;
        if (!r) begin
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL in_ready: got %b want %b (instr %h)", in_ready, exp_rdy, ins);
            end
            acc = v && exp_rdy;
        end
        if (r) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
            m_busy = 0; m_valid = 0;
        end else begin
            if (wbe && wrd != 0) begin m_rf[wrd] = wdat; m_busy[wrd] = 0; end
            if (acc) begin
                m_valid    = 1;
                m_exp      = {ins[6:2], ins[14:12], ins[30], a, b, d, wr && d != 0, ill};
                m_imm      = im;
                m_imm_care = (ins[6:2] != 5'b01100);
                if (wr && d != 0) m_busy[d] = 1;
            end else if (ordy) begin
                m_valid = 0;
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== m_valid) begin
            n_fail++;
            $display("FAIL out_valid: got %b want %b", out_valid, m_valid);
        end
        if (m_valid) begin
            act = {opcode, func3, func7, operand1, operand2, rd, rd_we, illegal};
            n_checks++;
            if (act !== m_exp) begin
                n_fail++;
                $display("FAIL bundle: got %h want %h", act, m_exp);
            end
            if (m_imm_care) begin
                n_checks++;
                if (imm !== m_imm) begin
                    n_fail++;
                    $display("FAIL imm: got %h want %h", imm, m_imm);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(1, 1, 32'h0050_0093, 32'h100, 1, 0, 5'd0, 32'd0);
        cycle(1, 1, 32'h0050_0093, 32'h100, 1, 1, 5'd3, 32'hDEAD_BEEF);
        n_checks++;
        if ({out_valid, opcode, func3, func7, operand1, operand2, imm, rd, rd_we, illegal} !== 114'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b op1=%h op2=%h imm=%h rd=%0d want all 0",
                     out_valid, operand1, operand2, imm, rd);
        end
        rst = 1'b0; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        // ADD x4,x3,x3: x3 must still be 0 after the writeback during reset
        cycle(0, 1, 32'h0031_8233, 32'h104, 1, 0, 5'd0, 32'd0);
        n_checks++;
        if (operand1 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_wb_ignored: got %h want 0", operand1);
        end
    endtask

    task automatic test_addi();
        cycle(0, 1, 32'h0050_0093, 32'h200, 1, 0, 5'd0, 32'd0);
        n_checks++;
        if ({out_valid, opcode, func3, operand1, operand2, rd, rd_we} !==
            {1'b1, 5'b00100, 3'b000, 32'd0, 32'd5, 5'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL addi: got v=%b opc=%b f3=%b op1=%h op2=%h rd=%0d we=%b want 1/00100/000/0/5/1/1",
                     out_valid, opcode, func3, operand1, operand2, rd, rd_we);
        end
    endtask

    task automatic test_hazard();
        int at;
        cycle(0, 1, 32'h0010_8133, 32'h204, 1, 0, 5'd0, 32'd0);
        n_checks++;
        if (obs_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_stall: in_ready got %b want 0", obs_rdy);
        end
        at = -1;
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, 32'h0010_8133, 32'h204, 1, k == 0, 5'd1, 32'd5);
            if (obs_rdy) begin at = k; break; end
        end
        n_checks++;
        if (at != (BYP ? 0 : 1)) begin
            n_fail++;
            $display("FAIL hazard_accept_cycle: got %0d want %0d", at, BYP ? 0 : 1);
        end
        n_checks++;
        if ({operand1, operand2, rd} !== {32'd5, 32'd5, 5'd2}) begin
            n_fail++;
            $display("FAIL hazard_operands: got op1=%h op2=%h rd=%0d want 5/5/2", operand1, operand2, rd);
        end
    endtask

    task automatic test_lui();
        cycle(0, 1, 32'h1234_51B7, 32'h300, 1, 0, 5'd0, 32'd0);
        n_checks++;
        if ({operand1, operand2, illegal, rd} !== {32'd0, 32'h0001_2345, 1'b0, 5'd3}) begin
            n_fail++;
            $display("FAIL lui: got op1=%h op2=%h ill=%b rd=%0d want 0/00012345/0/3",
                     operand1, operand2, illegal, rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ins [4];
        for (int i = 0; i < 4; i++)
            ins[i] = {20'hA0001 + 20'(i), 5'(5 + i), 7'b0110111};
        cycle(0, 1, ins[0], 32'h400, 1, 0, 5'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, ins[1], 32'h404, 0, 0, 5'd0, 32'd0);
            n_checks++;
            if ({obs_rdy, out_valid, operand2, rd} !== {1'b0, 1'b1, 32'h000A_0001, 5'd5}) begin
                n_fail++;
                $display("FAIL hold: got rdy=%b v=%b op2=%h rd=%0d want 0/1/000a0001/5",
                         obs_rdy, out_valid, operand2, rd);
            end
        end
        for (int k = 1; k < 4; k++) begin
            cycle(0, 1, ins[k], 32'h404, 1, 0, 5'd0, 32'd0);
            n_checks++;
            if ({out_valid, operand2, rd} !== {1'b1, 32'h000A_0001 + 32'(k), 5'(5 + k)}) begin
                n_fail++;
                $display("FAIL handover%0d: got v=%b op2=%h rd=%0d want 1/%h/%0d",
                         k, out_valid, operand2, rd, 32'h000A_0001 + 32'(k), 5 + k);
            end
        end
        cycle(0, 0, 32'd0, 32'd0, 1, 0, 5'd0, 32'd0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_x0_write();
        cycle(0, 0, 32'd0, 32'd0, 1, 1, 5'd0, 32'hFFFF_FFFF);
        cycle(0, 1, 32'h0000_04B3, 32'h500, 1, 0, 5'd0, 32'd0);   // ADD x9,x0,x0
        n_checks++;
        if ({operand1, operand2} !== 64'd0) begin
            n_fail++;
            $display("FAIL x0_read: got op1=%h op2=%h want 0/0", operand1, operand2);
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 1, 32'h0050_0093, 32'h600, 1, 0, 5'd0, 32'd0);
        cycle(0, 0, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        cycle(1, 0, 32'd0, 32'd0, 0, 1, 5'd1, 32'd7);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_valid: got %b want 0", out_valid);
        end
        cycle(0, 1, 32'h0010_8133, 32'h604, 1, 0, 5'd0, 32'd0);
        n_checks++;
        if ({obs_rdy, out_valid, operand1, operand2} !== {1'b1, 1'b1, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_add: got rdy=%b v=%b op1=%h op2=%h want 1/1/0/0",
                     obs_rdy, out_valid, operand1, operand2);
        end
    endtask

    task automatic test_random();
        logic [4:0]  opl [10] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000,
                                 5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b11100};
        logic [31:0] ins;
        logic [4:0]  wrd;
        bit          wbe;
        int          busy_list [$];
        for (int n = 0; n < 1500; n++) begin
            ins        = $urandom;
            ins[6:0]   = {opl[$urandom_range(0, 9)], 2'b11};
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            wbe = ($urandom_range(0, 9) < 4);
            busy_list.delete();
            for (int r = 1; r < 8; r++) if (m_busy[r]) busy_list.push_back(r);
            if (busy_list.size() > 0 && $urandom_range(0, 3) != 0)
                wrd = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
            else
                wrd = 5'($urandom_range(0, 7));
            cycle(0, $urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 9) < 7,
                  wbe, wrd, $urandom);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        wb_en = 0; wb_rd = 0; wb_data = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        m_busy = 0; m_valid = 0; m_exp = 0; m_imm = 0; m_imm_care = 0; obs_rdy = 0;
        @(negedge clk);
        test_reset();
        test_addi();
        test_hazard();
        test_lui();
        test_backpressure();
        test_x0_write();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
